mini_src_control_unit: RTL

- Hardwired control sequencer for the Mini SRC datapath.
- Fetches an instruction, decodes the IR, and drives every datapath load-enable, bus select, ALU op and GP-register address, one control step per clock.
- Drives the same control pins on `datapath` that benches currently toggle by hand.
- Adds a req/ack memory-read handshake so instruction fetch and `ld` tolerate wait states.

---
 rtl/mini_src_ctrl_pkg.sv | 60 ++++++
 rtl/mini_src_control_unit_if.sv | 38 +++
 rtl/mini_src_ctrl_decode.sv | 33 +++
 rtl/mini_src_control_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mini_src_ctrl_pkg.sv
// Shared constants and types for the Mini SRC hardwired control unit.
package mini_src_ctrl_pkg;

   localparam int unsigned OpW   = 5;
   localparam int unsigned AddrW = 4;
   localparam int unsigned BusW  = 5;
   localparam int unsigned AluW  = 4;
   localparam int unsigned IrW   = 32;

   // IR field positions (least-significant bit of each field)
   localparam int unsigned OpLsb = 27;
   localparam int unsigned RaLsb = 23;
   localparam int unsigned RbLsb = 19;
   localparam int unsigned RcLsb = 15;

   // Opcodes
   localparam logic [OpW-1:0] OpLd   = 5'b00000;
   localparam logic [OpW-1:0] OpAdd  = 5'b00011;
   localparam logic [OpW-1:0] OpSub  = 5'b00100;
   localparam logic [OpW-1:0] OpAnd  = 5'b00101;
   localparam logic [OpW-1:0] OpOr   = 5'b00110;
   localparam logic [OpW-1:0] OpShr  = 5'b01001;
   localparam logic [OpW-1:0] OpShl  = 5'b01011;
   localparam logic [OpW-1:0] OpAddi = 5'b01100;
   localparam logic [OpW-1:0] OpAndi = 5'b01101;
   localparam logic [OpW-1:0] OpOri  = 5'b01110;
   localparam logic [OpW-1:0] OpNeg  = 5'b10001;
   localparam logic [OpW-1:0] OpNot  = 5'b10010;
   localparam logic [OpW-1:0] OpNop  = 5'b11010;
   localparam logic [OpW-1:0] OpHalt = 5'b11011;

   // Bus sources above the GP registers (codes 0-15 select R0-R15)
   localparam logic [BusW-1:0] BusHi    = 5'd16;
   localparam logic [BusW-1:0] BusLo    = 5'd17;
   localparam logic [BusW-1:0] BusZhigh = 5'd18;
   localparam logic [BusW-1:0] BusZlow  = 5'd19;
   localparam logic [BusW-1:0] BusPc    = 5'd20;
   localparam logic [BusW-1:0] BusMdr   = 5'd21;
   localparam logic [BusW-1:0] BusInPort = 5'd22;
   localparam logic [BusW-1:0] BusCSext = 5'd23;

   // ALU operations
   localparam logic [AluW-1:0] AluAnd = 4'b0000;
   localparam logic [AluW-1:0] AluOr  = 4'b0001;
   localparam logic [AluW-1:0] AluAdd = 4'b0010;
   localparam logic [AluW-1:0] AluSub = 4'b0011;
   localparam logic [AluW-1:0] AluShr = 4'b0100;
   localparam logic [AluW-1:0] AluShl = 4'b0101;
   localparam logic [AluW-1:0] AluNot = 4'b0110;
   localparam logic [AluW-1:0] AluNeg = 4'b0111;

   typedef enum logic [3:0] {
      StIdle, StT0, StT1, StT1W, StT2, StT3, StT4, StT5, StT6, StT7, StHalted
   } state_e;

   typedef enum logic [2:0] {
      ClsRtype, ClsImm, ClsUnary, ClsLd, ClsNop, ClsHalt, ClsIllegal
   } instr_class_e;

endpackage

// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the sequencer (master) and the Mini SRC datapath/memory (slave).
interface mini_src_control_unit_if;
   import mini_src_ctrl_pkg::*;

   logic              run;
   logic [IrW-1:0]    ir_in;
   logic              mem_ack;
   logic              mem_rd;
   logic              e_PC;
   logic              e_IR;
   logic              e_Y;
   logic              e_Z;
   logic              e_HI;
   logic              e_LO;
   logic              e_MDR;
   logic              e_MAR;
   logic              e_GP;
   logic              MDR_read;
   logic              incPC;
   logic [AddrW-1:0]  GP_addr;
   logic [BusW-1:0]   BusDataSelect;
   logic [AluW-1:0]   ALU_op;
   logic              halted;
   logic              illegal;

   modport master (
      input  run, ir_in, mem_ack,
      output mem_rd, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
             MDR_read, incPC, GP_addr, BusDataSelect, ALU_op, halted, illegal
   );

   modport slave (
      output run, ir_in, mem_ack,
      input  mem_rd, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
             MDR_read, incPC, GP_addr, BusDataSelect, ALU_op, halted, illegal
   );

endinterface

// File: rtl/mini_src_ctrl_decode.sv
// Opcode decoder: instruction class and the ALU operation it needs.
module mini_src_ctrl_decode
   import mini_src_ctrl_pkg::*;
(
   input  logic [OpW-1:0]  opcode,
   output instr_class_e    instr_class,
   output logic [AluW-1:0] alu_op
);

   // Pure table lookup; undefined opcodes fall through to ClsIllegal
   always_comb begin
      instr_class = ClsIllegal;
      alu_op      = AluAnd;
      case (opcode)
         OpLd:    begin instr_class = ClsLd;    alu_op = AluAdd; end
         OpAdd:   begin instr_class = ClsRtype; alu_op = AluAdd; end
         OpSub:   begin instr_class = ClsRtype; alu_op = AluSub; end
         OpAnd:   begin instr_class = ClsRtype; alu_op = AluAnd; end
         OpOr:    begin instr_class = ClsRtype; alu_op = AluOr;  end
         OpShr:   begin instr_class = ClsRtype; alu_op = AluShr; end
         OpShl:   begin instr_class = ClsRtype; alu_op = AluShl; end
         OpAddi:  begin instr_class = ClsImm;   alu_op = AluAdd; end
         OpAndi:  begin instr_class = ClsImm;   alu_op = AluAnd; end
         OpOri:   begin instr_class = ClsImm;   alu_op = AluOr;  end
         OpNeg:   begin instr_class = ClsUnary; alu_op = AluNeg; end
         OpNot:   begin instr_class = ClsUnary; alu_op = AluNot; end
         OpNop:   instr_class = ClsNop;
         OpHalt:  instr_class = ClsHalt;
         default: instr_class = ClsIllegal;
      endcase
   end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Mini SRC sequencer: fetch, decode and execute one control step per clock.
module mini_src_control_unit
   import mini_src_ctrl_pkg::*;
#(
   parameter int unsigned IMM_W  = 19,
   parameter int unsigned ADDR_W = 4
) (
   input logic                     clock,
   input logic                     clear,
   mini_src_control_unit_if.master ctl
);

   state_e            state_q, state_d;
   instr_class_e      instr_class;
   logic [AluW-1:0]   alu_op;
   logic [ADDR_W-1:0] ra, rb, rc;
   logic              unused_imm;

   assign ra = ctl.ir_in[RaLsb +: ADDR_W];
   assign rb = ctl.ir_in[RbLsb +: ADDR_W];
   assign rc = ctl.ir_in[RcLsb +: ADDR_W];

   // The immediate itself is sign-extended by the datapath, never seen here
   assign unused_imm = ^ctl.ir_in[IMM_W-ADDR_W-1:0];

   mini_src_ctrl_decode u_decode (
      .opcode      (ctl.ir_in[OpLsb +: OpW]),
      .instr_class (instr_class),
      .alu_op      (alu_op)
   );

   // State register; clear drops straight to idle so a pending read is abandoned
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next control step
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (ctl.run) state_d = StT0;
         StT0:     state_d = StT1;
         StT1:     state_d = ctl.mem_ack ? StT2 : StT1W;
         StT1W:    if (ctl.mem_ack) state_d = StT2;
         StT2:     state_d = StT3;
         StT3: begin
            unique case (instr_class)
               ClsRtype, ClsImm, ClsLd: state_d = StT4;
               ClsUnary:                state_d = StT5;
               ClsHalt:                 state_d = StHalted;
               default:                 state_d = StT0;
            endcase
         end
         StT4:     state_d = StT5;
         StT5:     state_d = (instr_class == ClsLd) ? StT6 : StT0;
         StT6:     if (ctl.mem_ack) state_d = StT7;
         StT7:     state_d = StT0;
         StHalted: state_d = StHalted;
         default:  state_d = StIdle;
      endcase
   end

   // Control outputs for the current step; anything not driven below stays 0
   always_comb begin
      ctl.mem_rd        = 1'b0;
      ctl.e_PC          = 1'b0;
      ctl.e_IR          = 1'b0;
      ctl.e_Y           = 1'b0;
      ctl.e_Z           = 1'b0;
      ctl.e_HI          = 1'b0;
      ctl.e_LO          = 1'b0;
      ctl.e_MDR         = 1'b0;
      ctl.e_MAR         = 1'b0;
      ctl.e_GP          = 1'b0;
      ctl.MDR_read      = 1'b0;
      ctl.incPC         = 1'b0;
      ctl.GP_addr       = '0;
      ctl.BusDataSelect = '0;
      ctl.ALU_op        = '0;
      ctl.halted        = 1'b0;
      ctl.illegal       = 1'b0;
      unique case (state_q)
         StT0: begin
            ctl.BusDataSelect = BusPc;
            ctl.e_MAR         = 1'b1;
            ctl.incPC         = 1'b1;
            ctl.e_Z           = 1'b1;
         end
         StT1: begin
            ctl.BusDataSelect = BusZlow;
            ctl.e_PC          = 1'b1;
            ctl.mem_rd        = 1'b1;
            ctl.MDR_read      = ctl.mem_ack;
            ctl.e_MDR         = ctl.mem_ack;
         end
         StT1W, StT6: begin
            ctl.mem_rd   = 1'b1;
            ctl.MDR_read = ctl.mem_ack;
            ctl.e_MDR    = ctl.mem_ack;
         end
         StT2: begin
            ctl.BusDataSelect = BusMdr;
            ctl.e_IR          = 1'b1;
         end
         StT3: begin
            unique case (instr_class)
               ClsRtype, ClsImm, ClsLd: begin
                  ctl.BusDataSelect = BusW'(rb);
                  ctl.e_Y           = 1'b1;
               end
               ClsUnary: begin
                  ctl.BusDataSelect = BusW'(rb);
                  ctl.ALU_op        = alu_op;
                  ctl.e_Z           = 1'b1;
               end
               ClsIllegal: ctl.illegal = 1'b1;
               default: ;
            endcase
         end
         StT4: begin
            ctl.BusDataSelect = (instr_class == ClsRtype) ? BusW'(rc) : BusCSext;
            ctl.ALU_op        = alu_op;
            ctl.e_Z           = 1'b1;
         end
         StT5: begin
            ctl.BusDataSelect = BusZlow;
            if (instr_class == ClsLd) begin
               ctl.e_MAR = 1'b1;
            end else begin
               ctl.GP_addr = AddrW'(ra);
               ctl.e_GP    = 1'b1;
            end
         end
         StT7: begin
            ctl.BusDataSelect = BusMdr;
            ctl.GP_addr       = AddrW'(ra);
            ctl.e_GP          = 1'b1;
         end
         StHalted: ctl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule
